// File: rtl/axis_demod_seq_ctrl.sv
// rtl/axis_demod_seq_ctrl.sv - run-level sequencer gating the QPSK demodulator streams
module axis_demod_seq_ctrl #(
  parameter int SYM_PER_FRAME  = 64,
  parameter int WORD_PER_FRAME = 2,
  parameter int FRAME_W        = 16,
  parameter int TMO_W          = 16,
  parameter int FLUSH_CYC      = 2
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic [TMO_W-1:0]   tmo_cycles,
  input  logic               up_tvalid,
  input  logic               up_tlast,
  output logic               up_tready,
  output logic               dm_tvalid,
  input  logic               dm_tready,
  input  logic               dmo_tvalid,
  input  logic               dmo_tready,
  input  logic               dmo_tlast,
  output logic               demod_en,
  output logic               demod_rstn,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frames_in,
  output logic [FRAME_W-1:0] frames_out,
  output logic               err_tmo,
  output logic               err_align
);

  localparam int SC_W = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
  localparam int WC_W = (WORD_PER_FRAME > 1) ? $clog2(WORD_PER_FRAME) : 1;
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [SC_W-1:0]    SYM_LAST   = SC_W'(SYM_PER_FRAME - 1);
  localparam logic [WC_W-1:0]    WORD_LAST  = WC_W'(WORD_PER_FRAME - 1);
  localparam logic [FC_W-1:0]    FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] nf_lat;
  logic [TMO_W-1:0]   tmo_lat;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [SC_W-1:0]    sym_cnt;
  logic [WC_W-1:0]    word_cnt;
  logic [FC_W-1:0]    flush_cnt;

  logic               in_run;
  logic               in_mon;
  logic               in_hs;
  logic               out_hs;
  logic               sym_last;
  logic               word_last;
  logic               in_bad;
  logic               out_bad;
  logic               in_frame;
  logic               out_frame;
  logic               tmo_hit;
  logic               start_ok;
  logic [FRAME_W-1:0] fi_nx;
  logic [FRAME_W-1:0] fo_nx;

  // Streams pass straight through in RUN so the gate adds no latency.
  assign in_run    = (state == S_RUN);
  assign in_mon    = in_run | (state == S_DRAIN);
  assign up_tready = in_run & dm_tready;
  assign dm_tvalid = in_run & up_tvalid;

  assign in_hs     = up_tvalid & up_tready;
  assign out_hs    = in_mon & dmo_tvalid & dmo_tready;
  assign sym_last  = (sym_cnt == SYM_LAST);
  assign word_last = (word_cnt == WORD_LAST);
  assign in_bad    = in_hs & (up_tlast != sym_last);
  assign out_bad   = out_hs & (dmo_tlast != word_last);
  assign in_frame  = in_hs & sym_last & up_tlast;
  assign out_frame = out_hs & word_last & dmo_tlast;

  assign fi_nx = (in_frame && frames_in != FRAME_MAX) ? frames_in + FRAME_W'(1) : frames_in;
  assign fo_nx = (out_frame && frames_out != FRAME_MAX) ? frames_out + FRAME_W'(1) : frames_out;

  assign tmo_hit  = in_mon & ~in_hs & ~out_hs & (tmo_lat != '0) &
                    (tmo_cnt == tmo_lat - TMO_W'(1));
  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      nf_lat     <= '0;
      tmo_lat    <= '0;
      tmo_cnt    <= '0;
      sym_cnt    <= '0;
      word_cnt   <= '0;
      flush_cnt  <= '0;
      frames_in  <= '0;
      frames_out <= '0;
      demod_en   <= 1'b0;
      demod_rstn <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_tmo    <= 1'b0;
      err_align  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        demod_en   <= 1'b0;
        demod_rstn <= 1'b1;
        busy       <= 1'b0;
      end else if (start_ok) begin
        err_tmo   <= 1'b0;
        err_align <= 1'b0;
        if (num_frames == '0) begin
          state      <= S_IDLE;
          done       <= 1'b1;
          demod_en   <= 1'b0;
          demod_rstn <= 1'b1;
          busy       <= 1'b0;
        end else begin
          state      <= S_FLUSH;
          nf_lat     <= num_frames;
          tmo_lat    <= tmo_cycles;
          tmo_cnt    <= '0;
          sym_cnt    <= '0;
          word_cnt   <= '0;
          flush_cnt  <= '0;
          frames_in  <= '0;
          frames_out <= '0;
          demod_en   <= 1'b1;
          demod_rstn <= 1'b0;
          busy       <= 1'b1;
        end
      end else begin
        case (state)
          S_FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state      <= S_RUN;
              demod_rstn <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + FC_W'(1);
            end
          end
          S_RUN, S_DRAIN: begin
            if (in_hs) sym_cnt <= sym_last ? '0 : sym_cnt + SC_W'(1);
            if (out_hs) word_cnt <= word_last ? '0 : word_cnt + WC_W'(1);
            tmo_cnt    <= (in_hs | out_hs) ? '0 : tmo_cnt + TMO_W'(1);
            frames_in  <= fi_nx;
            frames_out <= fo_nx;
            // Both error sources may fire together; each flag is set independently.
            if (in_bad | out_bad | tmo_hit) begin
              err_align <= err_align | in_bad | out_bad;
              err_tmo   <= err_tmo | tmo_hit;
              state     <= S_ERR;
              demod_en  <= 1'b0;
              busy      <= 1'b0;
            end else if (fo_nx == nf_lat && (state == S_DRAIN || fi_nx == nf_lat)) begin
              state    <= S_DONE;
              done     <= 1'b1;
              demod_en <= 1'b0;
              busy     <= 1'b0;
            end else if (state == S_RUN && fi_nx == nf_lat) begin
              state <= S_DRAIN;
            end
          end
          S_DONE: state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_demod_seq_ctrl.sv
// tb/tb_axis_demod_seq_ctrl.sv - randomized self-checking bench for axis_demod_seq_ctrl
module tb_axis_demod_seq_ctrl;

  localparam int SYM_PER_FRAME  = 64;
  localparam int WORD_PER_FRAME = 2;
  localparam int SYM_PER_WORD   = SYM_PER_FRAME / WORD_PER_FRAME;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        abort;
  logic [15:0] num_frames;
  logic [15:0] tmo_cycles;
  logic        up_tvalid = 1'b0;
  logic        up_tlast = 1'b0;
  logic        up_tready;
  logic        dm_tvalid;
  logic        dm_tready = 1'b1;
  logic        dmo_tvalid = 1'b0;
  logic        dmo_tready = 1'b1;
  logic        dmo_tlast = 1'b0;
  logic        demod_en;
  logic        demod_rstn;
  logic        busy;
  logic        done;
  logic [15:0] frames_in;
  logic [15:0] frames_out;
  logic        err_tmo;
  logic        err_align;

  axis_demod_seq_ctrl dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .num_frames(num_frames), .tmo_cycles(tmo_cycles),
    .up_tvalid(up_tvalid), .up_tlast(up_tlast), .up_tready(up_tready),
    .dm_tvalid(dm_tvalid), .dm_tready(dm_tready),
    .dmo_tvalid(dmo_tvalid), .dmo_tready(dmo_tready), .dmo_tlast(dmo_tlast),
    .demod_en(demod_en), .demod_rstn(demod_rstn), .busy(busy), .done(done),
    .frames_in(frames_in), .frames_out(frames_out),
    .err_tmo(err_tmo), .err_align(err_align)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Knobs, written only by the main sequence.
  int feed_total = 0;
  int bad_idx = -1;
  int stall_at = -1;
  bit up_rand = 1'b0;
  bit dm_rand = 1'b0;
  bit dmo_rand = 1'b0;

  // Monitor/demodulator-model state, written only by the monitor.
  int cyc = 0;
  int fed = 0;
  int n_up_hs = 0;
  int n_dm_hs = 0;
  int n_out_hs = 0;
  int n_done = 0;
  int n_busy = 0;
  int rstn_low = 0;
  int flush_leak = 0;
  int en_bad = 0;
  int last_hs_cyc = 0;
  int tmo_cyc = 0;
  int pend = 0;
  int sym_acc = 0;
  bit wpar = 1'b0;
  bit prev_tmo = 1'b0;

  int b_up, b_dm, b_out, b_done, b_busy, b_rstn, b_leak, b_en;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural demodulator: one output word per SYM_PER_WORD accepted symbols,
  // tlast on every WORD_PER_FRAME-th word; flushed by demod_rstn.
  always begin
    @(posedge aclk);
    cyc++;
    if (areset) begin
      pend = 0;
      sym_acc = 0;
      wpar = 1'b0;
    end else begin
      if (start) fed = 0;
      else if (up_tvalid && up_tready) fed++;
      if (up_tvalid && up_tready) n_up_hs++;
      if (dm_tvalid && dm_tready) n_dm_hs++;
      if (dmo_tvalid && dmo_tready) n_out_hs++;
      if (done) n_done++;
      if (busy) n_busy++;
      if (!demod_rstn) begin
        rstn_low++;
        if (up_tready) flush_leak++;
      end
      if (up_tvalid && up_tready && !demod_en) en_bad++;
      if (busy && ((up_tvalid && up_tready) || (dmo_tvalid && dmo_tready))) last_hs_cyc = cyc;
      if (err_tmo && !prev_tmo) tmo_cyc = cyc;
      prev_tmo = err_tmo;
      if (!demod_rstn) begin
        pend = 0;
        sym_acc = 0;
        wpar = 1'b0;
      end else begin
        if (dmo_tvalid && dmo_tready) begin
          pend--;
          wpar = ~wpar;
        end
        if (dm_tvalid && dm_tready) begin
          sym_acc++;
          if (sym_acc == SYM_PER_WORD) begin
            sym_acc = 0;
            pend++;
          end
        end
      end
    end
    #1;
    dm_tready = dm_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_at >= 0 && n_out_hs >= stall_at) dmo_tready = 1'b0;
    else dmo_tready = dmo_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    dmo_tvalid = (pend > 0) && (dmo_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    dmo_tlast  = wpar;
    if (fed < feed_total) begin
      up_tvalid = up_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      up_tlast  = (fed == bad_idx) ? 1'b1 : ((fed % SYM_PER_FRAME) == SYM_PER_FRAME - 1);
    end else begin
      up_tvalid = 1'b0;
      up_tlast  = 1'b0;
    end
  end

  task automatic snap();
    b_up = n_up_hs; b_dm = n_dm_hs; b_out = n_out_hs; b_done = n_done;
    b_busy = n_busy; b_rstn = rstn_low; b_leak = flush_leak; b_en = en_bad;
  endtask

  task automatic do_start(input int nf, input int tmo);
    @(posedge aclk); #2;
    num_frames = 16'(nf);
    tmo_cycles = 16'(tmo);
    start = 1'b1;
    @(posedge aclk); #2;
    start = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge aclk); #2;
    abort = 1'b1;
    @(posedge aclk); #2;
    abort = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (done || err_tmo || err_align) break;
    end
    check(tag, int'(done | err_tmo | err_align), 1);
  endtask

  initial begin
    int nf;
    areset = 1'b1; start = 1'b0; abort = 1'b0;
    num_frames = '0; tmo_cycles = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_demod_en", int'(demod_en), 0);
    check("rst_demod_rstn", int'(demod_rstn), 1);
    check("rst_up_tready", int'(up_tready), 0);
    check("rst_dm_tvalid", int'(dm_tvalid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frames_in", int'(frames_in), 0);
    check("rst_frames_out", int'(frames_out), 0);
    check("rst_err", int'({err_tmo, err_align}), 0);
    @(posedge aclk); #2;
    areset = 1'b0;
    repeat (3) @(negedge aclk);

    // Nominal three-frame run with full readiness.
    snap();
    feed_total = 3 * SYM_PER_FRAME;
    do_start(3, 0);
    wait_end("nom_reached", 3000);
    repeat (5) @(negedge aclk);
    check("nom_rstn_low_cycles", rstn_low - b_rstn, 2);
    check("nom_flush_tready", flush_leak - b_leak, 0);
    check("nom_up_hs", n_up_hs - b_up, 192);
    check("nom_dm_hs", n_dm_hs - b_dm, 192);
    check("nom_out_words", n_out_hs - b_out, 6);
    check("nom_frames_in", int'(frames_in), 3);
    check("nom_frames_out", int'(frames_out), 3);
    check("nom_done_cycles", n_done - b_done, 1);
    check("nom_en_during_hs", en_bad - b_en, 0);
    check("nom_demod_en_after", int'(demod_en), 0);
    check("nom_busy_after", int'(busy), 0);
    check("nom_err", int'({err_tmo, err_align}), 0);

    // Early tlast at symbol 40 of frame 0.
    snap();
    bad_idx = 40;
    do_start(3, 0);
    wait_end("align_reached", 3000);
    repeat (3) @(negedge aclk);
    check("align_err_align", int'(err_align), 1);
    check("align_err_tmo", int'(err_tmo), 0);
    check("align_frames_in", int'(frames_in), 0);
    check("align_demod_en", int'(demod_en), 0);
    check("align_busy", int'(busy), 0);
    check("align_up_hs", n_up_hs - b_up, 41);
    check("align_gate_closed", int'(up_tready), 0);
    check("align_no_done", n_done - b_done, 0);
    feed_total = 0;
    bad_idx = -1;
    repeat (5) @(negedge aclk);

    // Zero-frame start from ERR: clears flags, pulses done, never busy.
    snap();
    do_start(0, 0);
    @(negedge aclk);
    check("zero_done_next", int'(done), 1);
    repeat (4) @(negedge aclk);
    check("zero_err_cleared", int'(err_align), 0);
    check("zero_done_cycles", n_done - b_done, 1);
    check("zero_busy_cycles", n_busy - b_busy, 0);

    // Timeout: output stalls after the first word.
    snap();
    feed_total = 2 * SYM_PER_FRAME;
    stall_at = n_out_hs + 1;
    do_start(2, 100);
    wait_end("tmo_reached", 2000);
    repeat (3) @(negedge aclk);
    check("tmo_err_tmo", int'(err_tmo), 1);
    check("tmo_err_align", int'(err_align), 0);
    check("tmo_latency", tmo_cyc - last_hs_cyc, 101);
    check("tmo_no_done", n_done - b_done, 0);
    check("tmo_frames_in", int'(frames_in), 2);
    check("tmo_frames_out", int'(frames_out), 0);
    check("tmo_out_words", n_out_hs - b_out, 1);
    check("tmo_demod_en", int'(demod_en), 0);
    do_abort();
    @(negedge aclk);
    check("abort_err_kept", int'(err_tmo), 1);
    check("abort_err_busy", int'(busy), 0);
    stall_at = -1;
    feed_total = 0;
    repeat (10) @(negedge aclk);

    // Abort in the middle of RUN.
    snap();
    feed_total = 4 * SYM_PER_FRAME;
    do_start(4, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (n_up_hs - b_up >= 100) break;
    end
    check("abort_mid_reached", int'(n_up_hs - b_up >= 100), 1);
    do_abort();
    @(negedge aclk);
    check("abort_busy", int'(busy), 0);
    check("abort_demod_en", int'(demod_en), 0);
    check("abort_demod_rstn", int'(demod_rstn), 1);
    check("abort_gate_closed", int'(up_tready), 0);
    check("abort_frames_in", int'(frames_in), 1);
    check("abort_flags", int'({err_tmo, err_align}), 0);
    feed_total = 0;
    repeat (10) @(negedge aclk);

    // Randomized backpressure on every stream.
    up_rand = 1'b1; dm_rand = 1'b1; dmo_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      nf = (r == 0) ? 4 : int'($urandom_range(1, 4));
      snap();
      feed_total = nf * SYM_PER_FRAME;
      do_start(nf, 1000);
      wait_end("rnd_reached", 10000);
      repeat (5) @(negedge aclk);
      check("rnd_up_hs", n_up_hs - b_up, nf * SYM_PER_FRAME);
      check("rnd_dm_hs", n_dm_hs - b_dm, nf * SYM_PER_FRAME);
      check("rnd_out_words", n_out_hs - b_out, nf * WORD_PER_FRAME);
      check("rnd_frames_in", int'(frames_in), nf);
      check("rnd_frames_out", int'(frames_out), nf);
      check("rnd_done_cycles", n_done - b_done, 1);
      check("rnd_en_during_hs", en_bad - b_en, 0);
      check("rnd_err", int'({err_tmo, err_align}), 0);
      check("rnd_demod_en_after", int'(demod_en), 0);
      feed_total = 0;
      repeat (5) @(negedge aclk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_demod_seq_ctrl.md
Name: axis_demod_seq_ctrl

Overview:
- Run-level sequencer for the QPSK demodulator stage of the OFDM receiver.
- Sits between the FFT output stream and the demodulator slave port, and monitors the demodulator master port.
- Flushes the demodulator, gates its enable, admits exactly num_frames frames of 64 symbols, and waits for all output words.
- Reports completion, frame count, timeout and framing-alignment errors to the AP register block.

Parameters:
- SYM_PER_FRAME, 64, input symbols per frame (counter width = clog2).
- WORD_PER_FRAME, 2, demodulated output words per frame.
- FRAME_W, 16, width of the frame counters.
- TMO_W, 16, width of the inactivity timeout counter.
- FLUSH_CYC, 2, cycles demod_rstn is held low at run start.

Ports:
- aclk, input, 1, clock.
- areset, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle run request (ignored unless state is IDLE, DONE or ERR).
- abort, input, 1, single-cycle abort (any state goes to IDLE).
- num_frames, input, FRAME_W, frames per run; sampled on start.
- tmo_cycles, input, TMO_W, inactivity limit; 0 disables the timeout; sampled on start.
- up_tvalid, input, 1, FFT symbol stream valid.
- up_tlast, input, 1, FFT last symbol of frame.
- up_tready, output, 1, FFT stream ready.
- dm_tvalid, output, 1, valid into the demodulator slave port.
- dm_tready, input, 1, demodulator slave ready.
- dmo_tvalid, input, 1, demodulator master valid (monitored only).
- dmo_tready, input, 1, downstream ready on the demodulator master (monitored only).
- dmo_tlast, input, 1, demodulator master last.
- demod_en, output, 1, demodulator enable.
- demod_rstn, output, 1, demodulator synchronous active-low reset.
- busy, output, 1, high in FLUSH, RUN and DRAIN.
- done, output, 1, one-cycle pulse at run completion.
- frames_in, output, FRAME_W, frames fully admitted.
- frames_out, output, FRAME_W, frames fully emitted.
- err_tmo, output, 1, sticky inactivity timeout flag.
- err_align, output, 1, sticky framing mismatch flag.

Behaviour:
- Reset values: state=IDLE; all counters 0; demod_en=0; demod_rstn=1; up_tready=0; dm_tvalid=0; busy=0; done=0; err_*=0.
- Handshake definitions:
  - in_hs = up_tvalid & up_tready.
  - out_hs = dmo_tvalid & dmo_tready.
- States:
  - IDLE:
    - All gates closed.
    - start with num_frames==0: done pulses the next cycle, state stays IDLE.
    - start with num_frames!=0: latch num_frames and tmo_cycles, clear counters and err flags, go to FLUSH.
  - FLUSH:
    - demod_rstn=0 and demod_en=1 for FLUSH_CYC cycles, then RUN.
    - Streams stay gated.
  - RUN:
    - demod_en=1; dm_tvalid=up_tvalid; up_tready=dm_tready (combinational pass-through, no added latency).
    - Each in_hs advances sym_cnt.
    - At sym_cnt==SYM_PER_FRAME-1: up_tlast must be 1; sym_cnt wraps to 0; frames_in increments.
    - When frames_in reaches the latched num_frames, go to DRAIN. The final accepted symbol is still passed through.
  - DRAIN:
    - up_tready=0, dm_tvalid=0, demod_en=1.
    - When frames_out equals num_frames, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - ERR:
    - demod_en=0, gates closed, flags held.
    - Exit only on start (re-run) or abort (to IDLE).
- Output monitoring in RUN and DRAIN:
  - Each out_hs advances word_cnt.
  - dmo_tlast must be 1 exactly when word_cnt==WORD_PER_FRAME-1; on that handshake word_cnt wraps and frames_out increments.
- Alignment errors:
  - up_tlast=1 on an in_hs before the last symbol index, or 0 on the last one, sets err_align.
  - Likewise for dmo_tlast against word_cnt.
  - Either case: go to ERR on the next edge.
- Timeout:
  - tmo_cnt counts cycles in RUN or DRAIN with neither in_hs nor out_hs; any handshake clears it.
  - When tmo_cycles!=0 and tmo_cnt==tmo_cycles-1 with no handshake: set err_tmo, go to ERR.
- Simultaneous events:
  - in_hs and out_hs in the same cycle both count.
  - Completing the last input frame and the last output frame in the same cycle goes from RUN directly to DONE.
  - An alignment error and a timeout in the same cycle set both flags.
- Priority:
  - areset (async) > abort > error > normal transitions.
  - abort forces IDLE with demod_en=0.
  - abort does not clear the err flags; start clears them.
- Counter widths:
  - frames_in and frames_out saturate at 2^FRAME_W-1; they never wrap within a run.
  - sym_cnt and word_cnt wrap only as defined above.

Test Plan:
- Nominal run: num_frames=3, tmo=0; feed 192 symbols with tlast every 64th; sink words with ready=1 -> 6 output words, frames_in=frames_out=3, done pulses once, demod_en=0 after.
- Flush: start -> demod_rstn low exactly 2 cycles, and up_tready=0 during those cycles.
- Early tlast: up_tlast at symbol 40 of frame 0 -> err_align=1, state ERR, demod_en=0, frames_in=0; a later start clears the flag.
- Timeout: tmo=100; stall dmo_tready after 1 word -> err_tmo set at the 100th idle cycle; done never pulses.
- Boundaries: num_frames=0 -> done pulse, busy stays 0. Abort mid-RUN -> IDLE next cycle, flags unchanged.
- Backpressure: random dm_tready and dmo_tready over 4 frames -> no symbol lost or duplicated (up/dm handshake counts equal, 256), done asserted.
